// File: rtl/micro_sequencer.sv
// Microprogram sequencer: micro-PC register, internal control store and opcode dispatch.
// Control outputs are decoded from the registered micro-PC; stall suppresses the write-side strobes.
module micro_sequencer #(
  parameter int UPC_W = 4,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero,
  input  logic             stall,
  output logic [UPC_W-1:0] upc,
  output logic [2:0]       trans_out,
  output logic             pc_en,
  output logic             reg_wr,
  output logic             mem_rd,
  output logic             iord,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal_op
);

  localparam logic [OP_W-1:0] OP_R   = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J   = OP_W'(6'b000010);

  localparam logic [UPC_W-1:0] S_FETCH   = UPC_W'(0);
  localparam logic [UPC_W-1:0] S_DECODE  = UPC_W'(1);
  localparam logic [UPC_W-1:0] S_MEMADDR = UPC_W'(2);
  localparam logic [UPC_W-1:0] S_MEMRD   = UPC_W'(3);
  localparam logic [UPC_W-1:0] S_MEMWB   = UPC_W'(4);
  localparam logic [UPC_W-1:0] S_MEMWR   = UPC_W'(5);
  localparam logic [UPC_W-1:0] S_EXEC    = UPC_W'(6);
  localparam logic [UPC_W-1:0] S_RWB     = UPC_W'(7);
  localparam logic [UPC_W-1:0] S_BRANCH  = UPC_W'(8);
  localparam logic [UPC_W-1:0] S_JUMP    = UPC_W'(9);

  localparam logic [2:0] TR_NONE   = 3'd0;
  localparam logic [2:0] TR_REGDST = 3'd1;
  localparam logic [2:0] TR_PCSRC1 = 3'd2;
  localparam logic [2:0] TR_PCSRC2 = 3'd3;
  localparam logic [2:0] TR_MEM2RG = 3'd4;
  localparam logic [2:0] TR_MEMWR  = 3'd5;
  localparam logic [2:0] TR_IRWR   = 3'd6;

  logic [UPC_W-1:0] upc_q, upc_d;
  logic             illegal_q, illegal_d;

  logic [2:0] cs_trans;
  logic       cs_pc_wr, cs_pc_wr_cond, cs_reg_wr;
  logic       cs_mem_rd, cs_iord, cs_alu_src_a;
  logic [1:0] cs_alu_src_b, cs_alu_op;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc_q     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      upc_q     <= upc_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state: sequencing plus the two dispatch points; unused states fall back to fetch
  always_comb begin
    upc_d     = upc_q;
    illegal_d = 1'b0;
    if (!stall) begin
      case (upc_q)
        S_FETCH: upc_d = S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_R:          upc_d = S_EXEC;
            OP_LW, OP_SW:  upc_d = S_MEMADDR;
            OP_BEQ:        upc_d = S_BRANCH;
            OP_J:          upc_d = S_JUMP;
            default: begin
              upc_d     = S_FETCH;
              illegal_d = 1'b1;
            end
          endcase
        end
        S_MEMADDR: begin
          case (opcode)
            OP_LW:   upc_d = S_MEMRD;
            OP_SW:   upc_d = S_MEMWR;
            default: upc_d = S_FETCH;
          endcase
        end
        S_MEMRD: upc_d = S_MEMWB;
        S_EXEC:  upc_d = S_RWB;
        default: upc_d = S_FETCH;
      endcase
    end
  end

  // Output decode: control store lookup, then stall masks the write-side strobes
  always_comb begin
    cs_trans      = TR_NONE;
    cs_pc_wr      = 1'b0;
    cs_pc_wr_cond = 1'b0;
    cs_reg_wr     = 1'b0;
    cs_mem_rd     = 1'b0;
    cs_iord       = 1'b0;
    cs_alu_src_a  = 1'b0;
    cs_alu_src_b  = 2'b00;
    cs_alu_op     = 2'b00;
    case (upc_q)
      S_FETCH: begin
        cs_mem_rd    = 1'b1;
        cs_alu_src_b = 2'b01;
        cs_pc_wr     = 1'b1;
        cs_trans     = TR_IRWR;
      end
      S_DECODE:  cs_alu_src_b = 2'b11;
      S_MEMADDR: begin
        cs_alu_src_a = 1'b1;
        cs_alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        cs_mem_rd = 1'b1;
        cs_iord   = 1'b1;
      end
      S_MEMWB: begin
        cs_reg_wr = 1'b1;
        cs_trans  = TR_MEM2RG;
      end
      S_MEMWR: begin
        cs_iord  = 1'b1;
        cs_trans = TR_MEMWR;
      end
      S_EXEC: begin
        cs_alu_src_a = 1'b1;
        cs_alu_op    = 2'b10;
      end
      S_RWB: begin
        cs_reg_wr = 1'b1;
        cs_trans  = TR_REGDST;
      end
      S_BRANCH: begin
        cs_alu_src_a  = 1'b1;
        cs_alu_op     = 2'b01;
        cs_pc_wr_cond = 1'b1;
        cs_trans      = TR_PCSRC1;
      end
      S_JUMP: begin
        cs_pc_wr = 1'b1;
        cs_trans = TR_PCSRC2;
      end
      default: ;
    endcase
  end

  assign upc        = upc_q;
  assign illegal_op = illegal_q;
  assign trans_out  = stall ? TR_NONE : cs_trans;
  assign pc_en      = !stall && (cs_pc_wr || (cs_pc_wr_cond && zero));
  assign reg_wr     = !stall && cs_reg_wr;
  assign mem_rd     = cs_mem_rd;
  assign iord       = cs_iord;
  assign alu_src_a  = cs_alu_src_a;
  assign alu_src_b  = cs_alu_src_b;
  assign alu_op     = cs_alu_op;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: an instruction-path model predicts every cycle's outputs,
// a monitor on the falling edge compares them against the DUT.
module tb_micro_sequencer;

  localparam int UPC_W = 4;
  localparam int OP_W  = 6;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  typedef struct packed {
    logic [3:0] upc;
    logic [2:0] trans;
    logic       pc_en;
    logic       reg_wr;
    logic       mem_rd;
    logic       iord;
    logic       a;
    logic [1:0] b;
    logic [1:0] op;
    logic       ill;
  } out_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [OP_W-1:0]  opcode;
  logic             zero;
  logic             stall;
  logic [UPC_W-1:0] upc;
  logic [2:0]       trans_out;
  logic             pc_en, reg_wr, mem_rd, iord, alu_src_a, illegal_op;
  logic [1:0]       alu_src_b, alu_op;

  int n_chk  = 0;
  int n_fail = 0;

  out_t sbq[$];

  // Reference model: current microstate, queue of microstates still to visit, pending illegal flag
  int cur;
  int pending[$];
  logic ill_p;

  micro_sequencer #(.UPC_W(UPC_W), .OP_W(OP_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .stall(stall),
    .upc(upc), .trans_out(trans_out), .pc_en(pc_en), .reg_wr(reg_wr),
    .mem_rd(mem_rd), .iord(iord), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic out_t expect_out(input int st, input logic s, input logic z, input logic ill);
    out_t o;
    logic pw, pwc;
    o = '0;
    pw = 1'b0;
    pwc = 1'b0;
    o.upc = 4'(st);
    case (st)
      0: begin o.mem_rd = 1; o.b = 2'b01; pw = 1; o.trans = 3'd6; end
      1: o.b = 2'b11;
      2: begin o.a = 1; o.b = 2'b10; end
      3: begin o.mem_rd = 1; o.iord = 1; end
      4: begin o.reg_wr = 1; o.trans = 3'd4; end
      5: begin o.iord = 1; o.trans = 3'd5; end
      6: begin o.a = 1; o.op = 2'b10; end
      7: begin o.reg_wr = 1; o.trans = 3'd1; end
      8: begin o.a = 1; o.op = 2'b01; pwc = 1; o.trans = 3'd2; end
      9: begin pw = 1; o.trans = 3'd3; end
      default: ;
    endcase
    o.pc_en = !s && (pw || (pwc && z));
    if (s) begin
      o.trans  = 3'd0;
      o.reg_wr = 1'b0;
    end
    o.ill = ill;
    return o;
  endfunction

  function automatic out_t actual_out();
    out_t o;
    o.upc = upc; o.trans = trans_out; o.pc_en = pc_en; o.reg_wr = reg_wr;
    o.mem_rd = mem_rd; o.iord = iord; o.a = alu_src_a; o.b = alu_src_b;
    o.op = alu_op; o.ill = illegal_op;
    return o;
  endfunction

  // One cycle: apply inputs, predict this cycle's outputs, advance the model, move to next cycle
  task automatic step(input logic s, input logic z, input logic [5:0] op);
    logic ill_n;
    stall  = s;
    zero   = z;
    opcode = op;
    sbq.push_back(expect_out(cur, s, z, ill_p));
    ill_n = 1'b0;
    if (!s) begin
      if (cur == 1) begin
        pending.delete();
        case (op)
          OP_LW:  pending = '{2, 3, 4};
          OP_SW:  pending = '{2, 5};
          OP_R:   pending = '{6, 7};
          OP_BEQ: pending = '{8};
          OP_J:   pending = '{9};
          default: ill_n = 1'b1;
        endcase
      end
      if (cur == 0)                 cur = 1;
      else if (pending.size() > 0)  cur = pending.pop_front();
      else                          cur = 0;
    end
    ill_p = ill_n;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 5))
      0: return OP_R;
      1: return OP_LW;
      2: return OP_SW;
      3: return OP_BEQ;
      4: return OP_J;
      default: return 6'($urandom);
    endcase
  endfunction

  // Monitor: every cycle with a prediction waiting is compared mid-cycle
  initial begin
    out_t e, a;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        a = actual_out();
        n_chk++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_outputs t=%0t state=%0d actual=%h expected=%h", $time, e.upc, a, e);
        end
      end
    end
  end

  initial begin
    logic [5:0] op_hold;
    reset  = 1'b1;
    opcode = '0;
    zero   = 1'b0;
    stall  = 1'b0;
    cur    = 0;
    ill_p  = 1'b0;
    #2;
    n_chk++;
    if (upc !== 4'd0 || illegal_op !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state upc=%0d illegal=%b required upc=0 illegal=0", upc, illegal_op);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    // lw with a three-cycle stall in the write-back microstate
    step(0, 0, OP_LW); step(0, 0, OP_LW); step(0, 0, OP_LW); step(0, 0, OP_LW);
    step(1, 0, OP_LW); step(1, 0, OP_LW); step(1, 0, OP_LW); step(0, 0, OP_LW);
    // sw, R-type, beq taken / not taken, j
    for (int i = 0; i < 4; i++) step(0, 0, OP_SW);
    for (int i = 0; i < 4; i++) step(0, 0, OP_R);
    for (int i = 0; i < 3; i++) step(0, 1, OP_BEQ);
    for (int i = 0; i < 3; i++) step(0, 0, OP_BEQ);
    for (int i = 0; i < 3; i++) step(0, 1, OP_J);
    // unknown opcode, followed by a fetch that shows the illegal pulse
    step(0, 0, 6'b111111); step(0, 0, 6'b111111);
    // stall in decode while the opcode changes: dispatch follows the unstalled edge
    step(0, 0, OP_LW); step(1, 0, OP_LW); step(1, 1, 6'b111111); step(0, 0, OP_R);
    step(0, 0, OP_R); step(0, 0, OP_R);
    // stall in fetch right after an illegal dispatch: pulse still lasts one cycle
    step(0, 0, OP_J); step(0, 0, 6'b110011); step(1, 0, OP_J); step(0, 0, OP_J);

    // randomized traffic
    op_hold = OP_R;
    for (int i = 0; i < 600; i++) begin
      logic s;
      s = ($urandom_range(0, 4) == 0);
      if (cur == 1) op_hold = s ? 6'($urandom) : pick_op();
      step(s, 1'($urandom), (cur == 1) ? op_hold : ((cur == 2) ? op_hold : 6'($urandom)));
      if (cur == 2 && i % 2 == 0) op_hold = op_hold;
    end

    // asynchronous reset while in memread
    while (cur != 0) step(0, 0, OP_R);
    step(0, 0, OP_LW); step(0, 0, OP_LW); step(0, 0, OP_LW);
    #2;
    reset = 1'b1;
    #1;
    n_chk++;
    if (upc !== 4'd0 || illegal_op !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset upc=%0d illegal=%b required upc=0 illegal=0", upc, illegal_op);
    end
    reset = 1'b0;
    cur   = 0;
    ill_p = 1'b0;
    pending.delete();
    for (int i = 0; i < 6; i++) step(0, 0, OP_SW);

    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d required=0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
